dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the line-wide DMEM strobe/done protocol.
- Sits below the atomic unit, or any other initiator on that protocol, and services single-line read/write requests against an internal line array.
- Read and write latencies are independently programmable.
- Serves as the on-chip data store for core-cluster simulation and for small FPGA builds.

Parameters:
XLEN, 64, address width
CLSIZE, 128, line width in bits; must be a power of two and at least 64
DEPTH, 256, number of lines in the array (power of two)
RD_LATENCY, 2, cycles from accept to read done_o; at least 1
WR_LATENCY, 1, cycles from accept to write done_o; at least 1

Ports:
clk_i  in  1  clock; all logic is rising-edge
rst_i  in  1  asynchronous, active-low reset
S_DMEM_strobe_i  in  1  request valid; level-sensitive
S_DMEM_addr_i  in  XLEN  byte address of the line
S_DMEM_rw_i  in  1  1 = write, 0 = read
S_DMEM_data_i  in  CLSIZE  write line
S_DMEM_done_o  out  1  one-cycle completion pulse
S_DMEM_data_o  out  CLSIZE  read line; valid while done_o is high and held afterwards
S_DMEM_err_o  out  1  address out of range; pulses together with done_o
busy_o  out  1  high from accept up to and including the done cycle

Behaviour:
- Address decode:
  - OFS = log2(CLSIZE/8); IDX = log2(DEPTH).
  - Line index = addr[OFS+IDX-1 : OFS]; addr[OFS-1:0] is ignored.
  - A request is in range iff addr[XLEN-1 : OFS+IDX] == 0.
- Reset (rst_i low, asynchronous):
  - state = IDLE.
  - done_o = 0, err_o = 0, busy_o = 0, data_o = 0, latency counter = 0.
  - Array contents are not cleared.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: strobe_i high at the clock edge accepts the request.
    - Latch addr, rw and data.
    - Load the counter with LAT-1, where LAT = rw ? WR_LATENCY : RD_LATENCY.
    - Go to DONE if LAT == 1, otherwise to BUSY.
  - BUSY: decrement the counter; go to DONE when the counter reaches 1. All inputs are ignored.
  - DONE (exactly one cycle):
    - done_o = 1.
    - Write: the array line is written at the edge entering DONE.
    - Read: data_o is loaded at the edge entering DONE with the array line, or with 0 if out of range.
    - err_o = 1 if out of range; an out-of-range write is dropped.
    - Next state is IDLE.
- Latency: a request accepted at edge k raises done_o in the cycle after edge k+LAT-1. That is exactly LAT cycles of busy_o.
- Handshake rules:
  - strobe_i is sampled only in IDLE; strobe_i during BUSY or DONE is ignored, not queued.
  - Since DONE always returns to IDLE, a strobe held high through done_o is re-accepted in the following cycle. Initiators must drop strobe on done; the atomic unit does.
  - Request fields are latched at accept, so later changes to addr/rw/data have no effect.
  - Minimum spacing between two accepts is LAT+1 cycles.
- Data rules:
  - data_o changes only on read completion; writes and out-of-range writes leave it unchanged.
  - A read accepted after a write's done cycle returns the written line.
  - No partial-line writes; the atomic unit merges the line before writing.
- Reset mid-operation: the request is abandoned and no done_o is issued. A write whose DONE edge has not occurred is not performed.
- busy_o = (state != IDLE).

Test Plan:
- Write then read, defaults:
  - Stimulus: write 0x1111..._2222... to addr 0x40 (line 4), then read 0x48.
  - Response: write done_o 1 cycle after accept; read done_o 2 cycles after accept; data_o = 0x1111..._2222...; err_o = 0.
- Latency sweep:
  - Stimulus: RD_LATENCY = 1, 3, 5 and WR_LATENCY = 1, 4.
  - Response: done_o exactly LAT cycles after accept; busy_o high for LAT cycles; single-cycle done pulse.
- Atomic-unit sequence:
  - Stimulus: read line 0x80, strobe held until done; one idle cycle; write of the modified line.
  - Response: exactly two done pulses; the subsequent read of 0x80 returns the modified line.
- Strobe held high continuously for 10 cycles, read, RD_LATENCY = 2:
  - Response: accepts at cycles 0, 3, 6, 9; done_o at 2, 5, 8; strobe ignored while busy_o is high.
- Out of range:
  - Stimulus: write to addr 0x1_0000 (DEPTH = 256, CLSIZE = 128), then read the same address.
  - Response: both done with err_o = 1; read data_o = 0; line 0 unchanged.
- Reset mid-operation:
  - Stimulus: rst_i low for 1 cycle during BUSY of a WR_LATENCY = 3 write to 0x100.
  - Response: no done_o; outputs = 0; a later read of 0x100 returns the old contents.

Source files
------------

// File: rtl/dmem_responder.sv
// Line-wide DMEM strobe/done responder backed by an internal line array.
// Read and write latencies are set independently by parameter.
module dmem_responder #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned CLSIZE     = 128,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned WR_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              S_DMEM_strobe_i,
    input  logic [XLEN-1:0]   S_DMEM_addr_i,
    input  logic              S_DMEM_rw_i,
    input  logic [CLSIZE-1:0] S_DMEM_data_i,
    output logic              S_DMEM_done_o,
    output logic [CLSIZE-1:0] S_DMEM_data_o,
    output logic              S_DMEM_err_o,
    output logic              busy_o
);

    localparam int unsigned OFS     = $clog2(CLSIZE / 8);
    localparam int unsigned IDX     = $clog2(DEPTH);
    localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);
    localparam logic             RD_ONE  = (RD_LATENCY == 1);
    localparam logic             WR_ONE  = (WR_LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               rw_q;
    logic               range_q;
    logic [IDX-1:0]     idx_q;
    logic [CLSIZE-1:0]  wdata_q;

    logic               done_q, err_q, busy_q;
    logic [CLSIZE-1:0]  rdata_q;

    logic [CLSIZE-1:0]  mem_q [DEPTH];

    logic               accept;
    logic [IDX-1:0]     idx_in;
    logic               range_in;
    logic               unused_addr_lsb;

    logic               rw_cur, range_cur;
    logic [IDX-1:0]     idx_cur;
    logic [CLSIZE-1:0]  wdata_cur;

    logic               done_d, busy_d, err_d, mem_we, rd_ld;

    assign accept          = (state_q == IDLE) && S_DMEM_strobe_i;
    assign idx_in          = S_DMEM_addr_i[OFS+IDX-1:OFS];
    assign unused_addr_lsb = ^S_DMEM_addr_i[OFS-1:0];

    // Range check only exists when the address has bits above the line index
    generate
        if (OFS + IDX < XLEN) begin : g_range
            assign range_in = (S_DMEM_addr_i[XLEN-1:OFS+IDX] == '0);
        end else begin : g_no_range
            assign range_in = 1'b1;
        end
    endgenerate

    // A one-cycle request enters DONE on its accept edge, before the latches fill
    assign rw_cur    = accept ? S_DMEM_rw_i   : rw_q;
    assign range_cur = accept ? range_in      : range_q;
    assign idx_cur   = accept ? idx_in        : idx_q;
    assign wdata_cur = accept ? S_DMEM_data_i : wdata_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and latency counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (S_DMEM_strobe_i) begin
                    cnt_d   = S_DMEM_rw_i ? WR_LOAD : RD_LOAD;
                    state_d = (S_DMEM_rw_i ? WR_ONE : RD_ONE) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next-cycle output values and array/read-data strobes
    always_comb begin
        done_d = 1'b0;
        busy_d = 1'b0;
        err_d  = 1'b0;
        mem_we = 1'b0;
        rd_ld  = 1'b0;
        busy_d = (state_d != IDLE);
        if (state_d == DONE) begin
            done_d = 1'b1;
            err_d  = !range_cur;
            mem_we = rw_cur && range_cur && rst_i;
            rd_ld  = !rw_cur;
        end
    end

    // Registered outputs and request latches
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            range_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            done_q <= done_d;
            busy_q <= busy_d;
            err_q  <= err_d;
            if (rd_ld) begin
                rdata_q <= range_cur ? mem_q[idx_cur] : '0;
            end
            if (accept) begin
                rw_q    <= S_DMEM_rw_i;
                range_q <= range_in;
                idx_q   <= idx_in;
                wdata_q <= S_DMEM_data_i;
            end
        end
    end

    // Line array; contents survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx_cur] <= wdata_cur;
        end
    end

    assign S_DMEM_done_o = done_q;
    assign S_DMEM_err_o  = err_q;
    assign S_DMEM_data_o = rdata_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances with different latencies
// share one request bus; expected values are hand-computed constants.
module tb_dmem_responder;

    localparam int unsigned RD_L [4] = '{2, 1, 3, 5};
    localparam int unsigned WR_L [4] = '{1, 4, 3, 1};

    localparam logic [127:0] PAT = 128'h1111_1111_1111_1111_2222_2222_2222_2222;
    localparam logic [127:0] LA  = 128'hdead_beef_0123_4567_89ab_cdef_0f0f_f0f0;
    localparam logic [127:0] LM  = 128'hdead_beef_0123_4567_89ab_cdef_0f0f_f00f;
    localparam logic [127:0] L0  = 128'h0000_aaaa_5555_0000_ffff_1234_8765_4321;
    localparam logic [127:0] OLD = 128'h0101_0202_0303_0404_0505_0606_0707_0808;
    localparam logic [127:0] NEW = 128'hf0f0_e0e0_d0d0_c0c0_b0b0_a0a0_9090_8080;

    logic         clk;
    logic         rst_n;
    logic         strobe;
    logic [63:0]  addr;
    logic         rw;
    logic [127:0] wdata;

    logic         done_v  [4];
    logic         err_v   [4];
    logic         busy_v  [4];
    logic [127:0] rdata_v [4];

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.RD_LATENCY(2), .WR_LATENCY(1)) u0 (
        .clk_i(clk), .rst_i(rst_n), .S_DMEM_strobe_i(strobe), .S_DMEM_addr_i(addr),
        .S_DMEM_rw_i(rw), .S_DMEM_data_i(wdata), .S_DMEM_done_o(done_v[0]),
        .S_DMEM_data_o(rdata_v[0]), .S_DMEM_err_o(err_v[0]), .busy_o(busy_v[0]));
    dmem_responder #(.RD_LATENCY(1), .WR_LATENCY(4)) u1 (
        .clk_i(clk), .rst_i(rst_n), .S_DMEM_strobe_i(strobe), .S_DMEM_addr_i(addr),
        .S_DMEM_rw_i(rw), .S_DMEM_data_i(wdata), .S_DMEM_done_o(done_v[1]),
        .S_DMEM_data_o(rdata_v[1]), .S_DMEM_err_o(err_v[1]), .busy_o(busy_v[1]));
    dmem_responder #(.RD_LATENCY(3), .WR_LATENCY(3)) u2 (
        .clk_i(clk), .rst_i(rst_n), .S_DMEM_strobe_i(strobe), .S_DMEM_addr_i(addr),
        .S_DMEM_rw_i(rw), .S_DMEM_data_i(wdata), .S_DMEM_done_o(done_v[2]),
        .S_DMEM_data_o(rdata_v[2]), .S_DMEM_err_o(err_v[2]), .busy_o(busy_v[2]));
    dmem_responder #(.RD_LATENCY(5), .WR_LATENCY(1)) u3 (
        .clk_i(clk), .rst_i(rst_n), .S_DMEM_strobe_i(strobe), .S_DMEM_addr_i(addr),
        .S_DMEM_rw_i(rw), .S_DMEM_data_i(wdata), .S_DMEM_done_o(done_v[3]),
        .S_DMEM_data_o(rdata_v[3]), .S_DMEM_err_o(err_v[3]), .busy_o(busy_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle strobe at the current negedge, then watch all instances for 12 cycles
    task automatic xact(input string name, input logic wr, input logic [63:0] a,
                        input logic [127:0] d, input logic exp_err);
        int   first [4];
        int   nd    [4];
        int   nb    [4];
        logic er    [4];
        int   lat;
        for (int i = 0; i < 4; i++) begin
            first[i] = 0; nd[i] = 0; nb[i] = 0; er[i] = 1'b0;
        end
        strobe = 1'b1; rw = wr; addr = a; wdata = d;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (done_v[i]) begin
                    if (first[i] == 0) first[i] = c;
                    nd[i]++;
                    er[i] = err_v[i];
                end
                if (busy_v[i]) nb[i]++;
            end
            if (c == 1) begin
                strobe = 1'b0; rw = ~wr; addr = '1; wdata = ~d;
            end
        end
        for (int i = 0; i < 4; i++) begin
            lat = wr ? int'(WR_L[i]) : int'(RD_L[i]);
            check($sformatf("%s_done_lat_u%0d", name, i), 128'(first[i]), 128'(lat));
            check($sformatf("%s_done_cnt_u%0d", name, i), 128'(nd[i]), 128'(1));
            check($sformatf("%s_busy_cnt_u%0d", name, i), 128'(nb[i]), 128'(lat));
            check($sformatf("%s_err_u%0d", name, i), 128'(er[i]), 128'(exp_err));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   pulses;
        logic seen;
        int   late_done;

        rst_n = 1'b0; strobe = 1'b0; addr = '0; rw = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_done_u%0d", i), 128'(done_v[i]), 128'(0));
            check($sformatf("rst_busy_u%0d", i), 128'(busy_v[i]), 128'(0));
            check($sformatf("rst_err_u%0d", i), 128'(err_v[i]), 128'(0));
            check($sformatf("rst_data_u%0d", i), rdata_v[i], 128'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read within the same line, plus latency sweep on every instance
        xact("wr40", 1'b1, 64'h40, PAT, 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("wr40_data_kept_u%0d", i), rdata_v[i], 128'(0));
        xact("rd48", 1'b0, 64'h48, 128'h0, 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("rd48_data_u%0d", i), rdata_v[i], PAT);

        // Atomic-unit style: read held until done, one idle cycle, write back
        xact("wr80", 1'b1, 64'h80, LA, 1'b0);
        pulses = 0;
        strobe = 1'b1; rw = 1'b0; addr = 64'h80;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done_v[0]) begin seen = 1'b1; pulses++; end
        end
        check("atom_rd_done_seen", 128'(seen), 128'(1));
        check("atom_rd_data", rdata_v[0], LA);
        strobe = 1'b0;
        @(negedge clk);
        if (done_v[0]) pulses++;
        strobe = 1'b1; rw = 1'b1; wdata = LM;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done_v[0]) begin seen = 1'b1; pulses++; end
        end
        check("atom_wr_done_seen", 128'(seen), 128'(1));
        strobe = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done_v[0]) pulses++;
        end
        check("atom_pulses", 128'(pulses), 128'(2));
        check("atom_wr_data_kept", rdata_v[0], LA);
        xact("rd80", 1'b0, 64'h80, 128'h0, 1'b0);
        check("rd80_modified_u0", rdata_v[0], LM);

        // Strobe held for 10 cycles on a RD_LATENCY=2 instance: accepts every 3rd edge
        strobe = 1'b1; rw = 1'b0; addr = 64'h40;
        @(posedge clk);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check($sformatf("held_done_c%0d", c), 128'(done_v[0]), 128'((c % 3) == 2));
            check($sformatf("held_busy_c%0d", c), 128'(busy_v[0]), 128'((c % 3) != 0));
            if (c == 10) strobe = 1'b0;
            @(posedge clk);
        end
        repeat (12) @(negedge clk);
        check("held_idle_busy", 128'(busy_v[0]), 128'(0));
        check("held_rdata", rdata_v[0], PAT);

        // Out of range: err on both, write dropped, read returns zero
        xact("wr0", 1'b1, 64'h0, L0, 1'b0);
        xact("rd0a", 1'b0, 64'h0, 128'h0, 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("rd0a_data_u%0d", i), rdata_v[i], L0);
        xact("wr_oor", 1'b1, 64'h1_0000, ~L0, 1'b1);
        for (int i = 0; i < 4; i++) check($sformatf("wr_oor_data_kept_u%0d", i), rdata_v[i], L0);
        xact("rd_oor", 1'b0, 64'h1_0000, 128'h0, 1'b1);
        for (int i = 0; i < 4; i++) check($sformatf("rd_oor_data_u%0d", i), rdata_v[i], 128'(0));
        xact("rd0b", 1'b0, 64'h0, 128'h0, 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("rd0b_data_u%0d", i), rdata_v[i], L0);

        // Reset during BUSY of a 3-cycle write abandons it
        xact("wr100_old", 1'b1, 64'h100, OLD, 1'b0);
        strobe = 1'b1; rw = 1'b1; addr = 64'h100; wdata = NEW;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_pre_busy_u2", 128'(busy_v[2]), 128'(1));
        strobe = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_done_u2", 128'(done_v[2]), 128'(0));
        check("rst_mid_busy_u2", 128'(busy_v[2]), 128'(0));
        check("rst_mid_err_u2", 128'(err_v[2]), 128'(0));
        check("rst_mid_data_u2", rdata_v[2], 128'(0));
        check("rst_mid_done_u0", 128'(done_v[0]), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done_v[1] || done_v[2]) late_done++;
        end
        check("rst_mid_no_done", 128'(late_done), 128'(0));
        xact("rd100", 1'b0, 64'h100, 128'h0, 1'b0);
        check("rd100_u0_new", rdata_v[0], NEW);
        check("rd100_u1_old", rdata_v[1], OLD);
        check("rd100_u2_old", rdata_v[2], OLD);
        check("rd100_u3_new", rdata_v[3], NEW);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
